dac_serial_tx: RTL and testbench

- Transmit end of the synth's audio output path. Takes unsigned WAVE_DEPTH-bit mixed samples from the waveform summing stage and serializes them to an external I2S-style DAC.
- Provides Bclk, Lrclk and Sdata, with a one-entry sample buffer and a valid/ready handshake.
- Mono source: the same sample is sent in both the left and right slots.

---
 rtl/synth_pkg.sv | 20 ++
 rtl/bclk_gen.sv | 43 ++++
 rtl/dac_serial_tx.sv | 141 ++++++++++++++
 tb/tb_dac_serial_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared synth constants and sample-format helpers for the audio output path.
package synth_pkg;

    localparam int unsigned SYNTH_WAVE_DEPTH = 8;
    localparam int unsigned SYNTH_SLOT_WIDTH = 16;

    // DAC channel select encoding on Lrclk.
    typedef enum logic {
        ChLeft  = 1'b0,
        ChRight = 1'b1
    } dac_chan_e;

    // Offset-binary to two's complement: invert the MSB of a depth-bit sample.
    // Supports depths up to 32 bits; callers truncate the result to their width.
    function automatic logic [31:0] offset_to_signed(input logic [31:0] sample,
                                                     input int unsigned depth);
        return sample ^ (32'd1 << (depth - 1));
    endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock generator: divides the system clock by 2*CLK_DIV and flags the
// system-clock cycle in which Bclk falls or rises. Shared with the ADC side.
module bclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n,
    output logic bclk_o,
    output logic fall_strobe_o,
    output logic rise_strobe_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic          term;

    // Divider count and Bclk toggle at the terminal count.
    always_comb begin
        term   = (cnt_q == TERM);
        cnt_d  = term ? '0 : cnt_q + CW'(1);
        bclk_d = term ? ~bclk_q : bclk_q;
    end

    // Divider state registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk_o        = bclk_q;
    // Strobes mark the cycle whose closing edge moves Bclk.
    assign fall_strobe_o = term & bclk_q;
    assign rise_strobe_o = term & ~bclk_q;

endmodule

// File: rtl/dac_serial_tx.sv
// Serial transmitter to an I2S-style DAC. Mono samples are sent in both slots,
// MSB first, with a one-entry hold buffer behind a valid/ready handshake.
// Build option DAC_SERIAL_TX_I2S_DELAY_EN: data lags Lrclk by one bit (standard
// I2S); otherwise the stream is left-justified.
module dac_serial_tx
    import synth_pkg::*;
#(
    parameter int unsigned WAVE_DEPTH = SYNTH_WAVE_DEPTH,
    parameter int unsigned SLOT_WIDTH = SYNTH_SLOT_WIDTH,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic [WAVE_DEPTH-1:0] waveform_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  underrun_o
);

    localparam int unsigned FW = 2 * SLOT_WIDTH;
    localparam int unsigned KW = $clog2(FW);
    localparam logic [KW-1:0] K_LAST = KW'(FW - 1);
    localparam logic [KW-1:0] K_RIGHT = KW'(SLOT_WIDTH);
`ifdef DAC_SERIAL_TX_I2S_DELAY_EN
    localparam logic [KW-1:0] K_LOAD = KW'(1);
`else
    localparam logic [KW-1:0] K_LOAD = KW'(0);
`endif
    localparam logic [WAVE_DEPTH-1:0] MIDSCALE = WAVE_DEPTH'(1) << (WAVE_DEPTH - 1);

    logic                  fall;
    logic                  rise_strobe_unused;

    // k_q is the index of the bit slot that the next Bclk fall starts.
    logic [KW-1:0]         k_q, k_d;
    logic [FW-1:0]         sr_q, sr_d;
    logic                  sdata_q, sdata_d;
    dac_chan_e             lrclk_q, lrclk_d;
    logic                  underrun_q, underrun_d;
    logic                  full_q, full_d;
    logic                  ready_q, ready_d;
    logic [WAVE_DEPTH-1:0] buf_q, buf_d;
    logic [WAVE_DEPTH-1:0] last_q, last_d;

    logic                  load;
    logic                  accept;
    logic [WAVE_DEPTH-1:0] conv;
    logic [SLOT_WIDTH-1:0] slot_word;
    logic [FW-1:0]         frame_word;

    bclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_bclk_gen (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .bclk_o       (bclk_o),
        .fall_strobe_o(fall),
        .rise_strobe_o(rise_strobe_unused)
    );

    // Frame word from the buffered sample, or the previous one on underrun.
    always_comb begin
        conv       = WAVE_DEPTH'(offset_to_signed(32'(full_q ? buf_q : last_q), WAVE_DEPTH));
        slot_word  = SLOT_WIDTH'(conv) << (SLOT_WIDTH - WAVE_DEPTH);
        frame_word = {slot_word, slot_word};
        load       = fall && (k_q == K_LOAD);
        // Load sees the old buffer state, so a full buffer blocks acceptance.
        accept     = sample_valid_i && !full_q;
    end

    // Next-state for slot counter, shifter, outputs and hold buffer.
    always_comb begin
        k_d        = k_q;
        sr_d       = sr_q;
        sdata_d    = sdata_q;
        lrclk_d    = lrclk_q;
        underrun_d = 1'b0;
        full_d     = full_q;
        buf_d      = buf_q;
        last_d     = last_q;

        if (fall) begin
            k_d     = (k_q == K_LAST) ? '0 : k_q + KW'(1);
            lrclk_d = (k_q >= K_RIGHT) ? ChRight : ChLeft;
            if (load) begin
                sdata_d    = frame_word[FW-1];
                sr_d       = frame_word << 1;
                underrun_d = !full_q;
                if (full_q) begin
                    last_d = buf_q;
                    full_d = 1'b0;
                end
            end else begin
                sdata_d = sr_q[FW-1];
                sr_d    = sr_q << 1;
            end
        end

        // An empty-buffer load still captures the incoming sample for next frame.
        if (accept) begin
            buf_d  = waveform_i;
            full_d = 1'b1;
        end

        ready_d = !full_d;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            sr_q       <= '0;
            sdata_q    <= 1'b0;
            lrclk_q    <= ChLeft;
            underrun_q <= 1'b0;
            full_q     <= 1'b0;
            ready_q    <= 1'b1;
            buf_q      <= '0;
            last_q     <= MIDSCALE;
        end else begin
            k_q        <= k_d;
            sr_q       <= sr_d;
            sdata_q    <= sdata_d;
            lrclk_q    <= lrclk_d;
            underrun_q <= underrun_d;
            full_q     <= full_d;
            ready_q    <= ready_d;
            buf_q      <= buf_d;
            last_q     <= last_d;
        end
    end

    assign sample_ready_o = ready_q;
    assign lrclk_o        = lrclk_q;
    assign sdata_o        = sdata_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx with WAVE_DEPTH=8, SLOT_WIDTH=16, CLK_DIV=2.
// A background recorder captures each frame's Sdata/Lrclk at mid-slot and the
// frame index of every Underrun pulse; the stimulus thread compares them.
module tb_dac_serial_tx;

    localparam int unsigned WD = 8;
    localparam int unsigned SW = 16;
    localparam int unsigned CD = 2;
`ifdef DAC_SERIAL_TX_I2S_DELAY_EN
    localparam int LO = 4;
    localparam bit DELAY = 1'b1;
`else
    localparam int LO = 0;
    localparam bit DELAY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  waveform = 8'h00;
    logic        sample_valid = 1'b0;
    logic        sample_ready_o, bclk_o, lrclk_o, sdata_o, underrun_o;

    int n_cmp = 0;
    int n_bad = 0;

    dac_serial_tx #(
        .WAVE_DEPTH(WD),
        .SLOT_WIDTH(SW),
        .CLK_DIV   (CD)
    ) dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .waveform_i    (waveform),
        .sample_valid_i(sample_valid),
        .sample_ready_o(sample_ready_o),
        .bclk_o        (bclk_o),
        .lrclk_o       (lrclk_o),
        .sdata_o       (sdata_o),
        .underrun_o    (underrun_o)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; read at the following falling edge.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int          base = 0;
    logic [31:0] cap_d [64];
    logic [31:0] cap_l [64];
    logic        ur_flag [64] = '{default: 1'b0};
    int          ur_bad = 0;
    int          unstable = 0;
    logic        s1, l1;

    // Slot k of frame m occupies cycles 4+128m+4k .. +3; sample at offsets 1..3.
    always @(negedge clk) begin
        if (rst_n && cyc >= 4) begin
            case ((cyc - 4) % 4)
                1: begin
                    s1 <= sdata_o;
                    l1 <= lrclk_o;
                end
                2: begin
                    cap_d[base + (cyc - 4) / 128][31 - ((cyc - 4) / 4) % 32] <= sdata_o;
                    cap_l[base + (cyc - 4) / 128][31 - ((cyc - 4) / 4) % 32] <= lrclk_o;
                end
                3: if (sdata_o !== s1 || lrclk_o !== l1) unstable <= unstable + 1;
                default: ;
            endcase
        end
        if (rst_n && underrun_o) begin
            if (cyc >= 4 + LO && (cyc - 4 - LO) % 128 == 0)
                ur_flag[base + (cyc - 4 - LO) / 128] <= 1'b1;
            else
                ur_bad <= ur_bad + 1;
        end
    end

    function automatic int lcyc(input int m);
        return 4 + 128 * m + LO;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cyc: reached %0d, expected %0d", cyc, t);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bclk"}, 32'(bclk_o), 32'd0);
        check({tag, "_lrclk"}, 32'(lrclk_o), 32'd0);
        check({tag, "_sdata"}, 32'(sdata_o), 32'd0);
        check({tag, "_ready"}, 32'(sample_ready_o), 32'd1);
        check({tag, "_underrun"}, 32'(underrun_o), 32'd0);
    endtask

    task automatic check_bclk(input string tag);
        for (int c = 0; c < 8; c++) begin
            wait_cyc(c);
            check($sformatf("%s_bclk_c%0d", tag, c), 32'(bclk_o), 32'((c / 2) % 2));
        end
    endtask

    // One-cycle offer into an empty buffer at cycle t.
    task automatic offer(input int t, input logic [7:0] s);
        wait_cyc(t);
        check($sformatf("offer_ready_c%0d", t), 32'(sample_ready_o), 32'd1);
        sample_valid = 1'b1;
        waveform = s;
        @(negedge clk);
        sample_valid = 1'b0;
        waveform = 8'($urandom);
        check($sformatf("offer_busy_c%0d", t), 32'(sample_ready_o), 32'd0);
    endtask

    task automatic check_frame(input int m, input logic [15:0] s, input logic [15:0] prev_s,
                               input bit ur);
        logic [31:0] f, e;
        wait_cyc(128 * m + 132 + LO);
        f = {s, s};
        e = DELAY ? {prev_s[0], f[31:1]} : f;
        check($sformatf("frame%0d_sdata", base + m), cap_d[base + m], e);
        check($sformatf("frame%0d_lrclk", base + m), cap_l[base + m], 32'h0000_FFFF);
        check($sformatf("frame%0d_underrun", base + m), 32'(ur_flag[base + m]), 32'(ur));
    endtask

    typedef struct {
        bit          offer;
        logic [7:0]  sample;
        logic [15:0] slot;
        bit          ur;
    } vec_t;

    vec_t        tbl[7];
    logic [15:0] slots2[8];
    bit          urs2[8];
    bit          pend;
    bit          exp_r;
    int          r_cyc;

    initial begin
        // Offer (before this frame's load) -> expected slot word and underrun.
        tbl[0] = '{1'b0, 8'h00, 16'h0000, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 16'h0000, 1'b1};
        tbl[2] = '{1'b1, 8'hFF, 16'h7F00, 1'b0};
        tbl[3] = '{1'b1, 8'h00, 16'h8000, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 16'h8000, 1'b1};
        tbl[5] = '{1'b1, 8'h12, 16'h9200, 1'b0};
        tbl[6] = '{1'b1, 8'hA5, 16'h2500, 1'b0};
        slots2 = '{16'h2500, 16'hB000, 16'hB100, 16'hB200,
                   16'hB300, 16'hB300, 16'hF700, 16'hF700};
        urs2   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        check_bclk("start");

        for (int m = 0; m < 7; m++) begin
            if (tbl[m].offer) offer(lcyc(m) - 20, tbl[m].sample);
            if (m > 0)
                check_frame(m - 1, tbl[m - 1].slot, (m > 1) ? tbl[m - 2].slot : 16'h0000,
                            tbl[m - 1].ur);
        end

        // Continuous valid with incrementing samples: one accept per frame.
        wait_cyc(lcyc(6) + 20);
        sample_valid = 1'b1;
        waveform = 8'h30;
        pend = 1'b0;
        for (int c = lcyc(6) + 20; c <= lcyc(9) + 1; c++) begin
            wait_cyc(c);
            if (pend) begin
                waveform = waveform + 8'd1;
                pend = 1'b0;
            end
            exp_r = (c == lcyc(6) + 20) || (c == lcyc(7)) || (c == lcyc(8)) || (c == lcyc(9));
            check($sformatf("stream_ready_c%0d", c), 32'(sample_ready_o), 32'(exp_r));
            if (sample_ready_o) pend = 1'b1;
        end
        sample_valid = 1'b0;

        // Offer into an empty buffer exactly in the load cycle.
        wait_cyc(lcyc(11) - 1);
        check("loadcyc_ready", 32'(sample_ready_o), 32'd1);
        sample_valid = 1'b1;
        waveform = 8'h77;
        @(negedge clk);
        sample_valid = 1'b0;
        check("loadcyc_underrun", 32'(underrun_o), 32'd1);
        check("loadcyc_buffered", 32'(sample_ready_o), 32'd0);

        for (int i = 0; i < 8; i++)
            check_frame(6 + i, slots2[i], (i == 0) ? tbl[5].slot : slots2[i - 1], urs2[i]);

        // Reset at slot k=10 of frame 14 with a sample waiting in the buffer.
        r_cyc = 4 + 128 * 14 + 4 * 10 + 1;
        offer(r_cyc - 5, 8'h55);
        wait_cyc(r_cyc);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        base = 32;
        rst_n = 1'b1;
        check_bclk("restart");
        check_frame(0, 16'h0000, 16'h0000, 1'b1);
        check_frame(1, 16'h0000, 16'h0000, 1'b1);

        check("stray_underrun", 32'(ur_bad), 32'd0);
        check("unstable_slots", 32'(unstable), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
